aes_ks_inv_seq: RTL and testbench

- Iterative inverse AES-128 key-schedule engine for the decryption datapath.
- Accepts the final round key (round NR) and streams round keys NR, NR-1, …, 0 with valid/ready backpressure.
- Computes one inverse key-schedule round per accepted output beat.
- Exact inverse of the core's forward key-schedule round: byte/column layout and S-box lane mapping are identical.

---
 rtl/aes_ks_inv_seq_pkg.sv | 24 ++
 rtl/aes_ks_inv_round.sv | 34 +++
 rtl/sbox_bp_umsk.sv | 47 ++++
 rtl/aes_ks_inv_seq.sv | 106 ++++++++++
 tb/tb_aes_ks_inv_seq.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/aes_ks_inv_seq_pkg.sv
// Shared definitions for the inverse AES-128 key-schedule sequencer.
//   AES_NR        : number of rounds (NR+1 round keys are streamed)
//   AES_RCON_LAST : round constant used by the forward round that made key NR
//   AES_KS_LANES  : S-box lanes in one key-schedule round (one per column byte)
//   ks_state_t    : sequencer FSM states
//   rcon_prev     : steps a round constant one round backwards
package aes_ks_inv_seq_pkg;

    localparam int          AES_NR        = 10;
    localparam logic [7:0]  AES_RCON_LAST = 8'h36;
    localparam int          AES_KS_LANES  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } ks_state_t;

    // Inverse of xtime in GF(2^8): undo the shift and, if the reduction
    // polynomial was folded in, fold it back out (0x11b >> 1 = 0x8d).
    function automatic logic [7:0] rcon_prev(input logic [7:0] r);
        return (r >> 1) ^ (r[0] ? 8'h8d : 8'h00);
    endfunction

endpackage

// File: rtl/aes_ks_inv_round.sv
// One inverse AES-128 key-schedule round (combinational).
//   kin  : round key r, byte i = kin[8i+:8]
//   rcon : round constant of the forward round r-1 -> r
//   kout : round key r-1
// Columns 1..3 are undone first by XORing neighbouring columns; the result's
// last column then feeds the S-boxes that undo column 0. Lane m of the S-box
// takes byte 12+m directly (the forward round uses no RotWord).
module aes_ks_inv_round
    import aes_ks_inv_seq_pkg::*;
(
    input  logic [127:0] kin,
    input  logic [7:0]   rcon,
    output logic [127:0] kout
);

    logic [7:0] sub [AES_KS_LANES];

    for (genvar j = 4; j < 16; j++) begin : g_col
        assign kout[8*j +: 8] = kin[8*j +: 8] ^ kin[8*(j-4) +: 8];
    end

    for (genvar m = 0; m < AES_KS_LANES; m++) begin : g_lane
        sbox_bp_umsk u_sbox (
            .a (kout[8*(12+m) +: 8]),
            .y (sub[m])
        );
        if (m == 0) begin : g_rc
            assign kout[7:0] = kin[7:0] ^ sub[0] ^ rcon;
        end else begin : g_norc
            assign kout[8*m +: 8] = kin[8*m +: 8] ^ sub[m];
        end
    end

endmodule

// File: rtl/sbox_bp_umsk.sv
// Unmasked AES forward S-box.
//   a : input byte
//   y : S(a)
// Computed as multiplicative inverse in GF(2^8) (a^254) followed by the AES
// affine transform, so no table ROM is needed.
module sbox_bp_umsk (
    input  logic [7:0] a,
    output logic [7:0] y
);

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = x;
        for (int i = 0; i < 8; i++) begin
            if (z[i]) acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // a^254 by square-and-multiply over the exponent bits 1111_1110;
    // maps 0 to 0 as the S-box definition requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (i != 0) r = gf_mul(r, x);
        end
        return r;
    endfunction

    logic [7:0] b;

    always_comb begin
        b = gf_inv(a);
        y = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
              ^ {b[3:0], b[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/aes_ks_inv_seq.sv
// Iterative inverse AES-128 key-schedule sequencer.
// Takes the final round key and streams round keys NR, NR-1, ..., 0, one
// inverse round per accepted beat, with valid/ready on both sides.
//   clk       : clock
//   rst_n     : asynchronous active-low reset
//   key_in    : round-NR key, byte i = key_in[8i+:8]
//   in_valid  : key_in valid
//   in_ready  : idle; key accepted on in_valid & in_ready
//   key_out   : current round key
//   out_round : round index of key_out
//   out_last  : high on the round-0 beat
//   out_valid : key_out valid
//   out_ready : consumer accepts beat on out_valid & out_ready
//   busy      : stream in progress
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a key; in_ready high
// EMIT  | presenting key_q for round_q; advance on accept, exit after 0
module aes_ks_inv_seq
    import aes_ks_inv_seq_pkg::*;
#(
    parameter int         NR        = AES_NR,
    parameter logic [7:0] RCON_LAST = AES_RCON_LAST
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] key_out,
    output logic [3:0]   out_round,
    output logic         out_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    localparam logic [3:0] ROUND_TOP = 4'(NR);

    ks_state_t    state_q, state_d;
    logic [127:0] key_q;
    logic [7:0]   rcon_q;
    logic [3:0]   round_q;
    logic [127:0] key_prev;
    logic         load;
    logic         step;

    aes_ks_inv_round u_round (
        .kin  (key_q),
        .rcon (rcon_q),
        .kout (key_prev)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            rcon_q  <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                key_q   <= key_in;
                rcon_q  <= RCON_LAST;
                round_q <= ROUND_TOP;
            end else if (step) begin
                key_q   <= key_prev;
                rcon_q  <= rcon_prev(rcon_q);
                round_q <= round_q - 4'd1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        step      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (round_q == 4'd0) state_d = IDLE;
                    else                 step    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign key_out   = key_q;
    assign out_round = round_q;
    // round_q rests at 0 after a stream, so qualify with the state.
    assign out_last  = (state_q == EMIT) && (round_q == 4'd0);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_aes_ks_inv_seq.sv
// Self-checking bench for aes_ks_inv_seq.
module tb_aes_ks_inv_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] key_in;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] key_out;
    logic [3:0]   out_round;
    logic         out_last;
    logic         out_valid;
    logic         out_ready;
    logic         busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_ks_inv_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .key_out   (key_out),
        .out_round (out_round),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    // Forward rcon of the round that produces round key r is RC_FWD[r-1].
    localparam logic [7:0] RC_FWD [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    logic [127:0] got      [0:10];
    logic [7:0]   rcon_got [0:10];
    logic [127:0] kexp     [0:10];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Forward key-schedule round with the core's lane mapping (no RotWord).
    function automatic logic [127:0] fwd_round(input logic [127:0] p, input logic [7:0] rc);
        logic [7:0]   pb [16];
        logic [7:0]   kb [16];
        logic [127:0] r;
        for (int i = 0; i < 16; i++) pb[i] = p[8*i +: 8];
        for (int m = 0; m < 4; m++) kb[m] = pb[m] ^ SBOX[pb[12+m]] ^ ((m == 0) ? rc : 8'h00);
        for (int j = 4; j < 16; j++) kb[j] = pb[j] ^ kb[j-4];
        for (int i = 0; i < 16; i++) r[8*i +: 8] = kb[i];
        return r;
    endfunction

    // mode 0: out_ready high; mode 1: out_ready pattern 1,0,0,1;
    // mode 2: in_valid held high with key2 after the first capture.
    // Entered on a negedge with the engine idle; returns on a negedge.
    task automatic stream(input logic [127:0] key, input int mode, input logic [127:0] key2);
        int           beats;
        int           cyc;
        logic [3:0]   exp_round;
        logic         stalled;
        logic [127:0] hk;
        logic [3:0]   hr;
        logic [3:0]   pat;
        pat       = 4'b1001;
        key_in    = key;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        #1;
        chk("in_ready_idle", 128'(in_ready), 128'(1'b1));
        @(negedge clk);
        if (mode == 2) key_in = key2;
        else           in_valid = 1'b0;
        #1;
        chk("lat_valid", 128'(out_valid), 128'(1'b1));
        chk("lat_round", 128'(out_round), 128'(4'd10));
        chk("lat_busy", 128'(busy), 128'(1'b1));
        beats     = 0;
        cyc       = 0;
        exp_round = 4'd10;
        stalled   = 1'b0;
        hk        = '0;
        hr        = '0;
        while (beats < 11 && cyc < 100) begin
            out_ready = (mode == 1) ? pat[cyc % 4] : 1'b1;
            #1;
            if (stalled) begin
                chk("stall_key", key_out, hk);
                chk("stall_round", 128'(out_round), 128'(hr));
            end
            chk("valid_in_stream", 128'(out_valid), 128'(1'b1));
            chk("in_ready_emit", 128'(in_ready), 128'(1'b0));
            if (out_valid && out_ready) begin
                chk("round_seq", 128'(out_round), 128'(exp_round));
                chk("last_flag", 128'(out_last), 128'(exp_round == 4'd0));
                if (out_round <= 4'd10) begin
                    got[out_round]      = key_out;
                    rcon_got[out_round] = dut.rcon_q;
                end
                beats++;
                exp_round = exp_round - 4'd1;
            end
            stalled = out_valid && !out_ready;
            hk      = key_out;
            hr      = out_round;
            @(negedge clk);
            cyc++;
        end
        chk("beat_count", 128'(beats), 128'(11));
        #1;
        chk("end_valid", 128'(out_valid), 128'(1'b0));
        chk("end_in_ready", 128'(in_ready), 128'(1'b1));
        chk("end_busy", 128'(busy), 128'(1'b0));
        chk("end_last", 128'(out_last), 128'(1'b0));
    endtask

    initial begin
        logic [127:0] key_b;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        key_in    = '0;
        #1 rst_n  = 1'b0;
        #1;
        chk("rst_valid", 128'(out_valid), 128'(1'b0));
        chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_last", 128'(out_last), 128'(1'b0));
        chk("rst_round", 128'(out_round), 128'(4'd0));
        chk("rst_key", key_out, 128'h0);
        chk("rst_rcon", 128'(dut.rcon_q), 128'(8'h00));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // All-zero final key, hand-computed first rounds.
        stream(128'h0, 0, 128'h0);
        chk("zero_r10", got[10], 128'h0);
        chk("zero_r9", got[9], 128'h00000000_00000000_00000000_63636355);
        chk("zero_r8", got[8], 128'h00000000_00000000_63636355_0000002d);
        for (int r = 1; r <= 10; r++) begin
            chk($sformatf("zero_fwd_r%0d", r), fwd_round(got[r-1], RC_FWD[r-1]), got[r]);
            chk($sformatf("rcon_r%0d", r), 128'(rcon_got[r]), 128'(RC_FWD[r-1]));
        end

        // Random original key, expanded forward by the model, streamed back with stalls.
        kexp[0] = {$urandom, $urandom, $urandom, $urandom};
        for (int r = 1; r <= 10; r++) kexp[r] = fwd_round(kexp[r-1], RC_FWD[r-1]);
        stream(kexp[10], 1, 128'h0);
        for (int r = 0; r <= 10; r++) chk($sformatf("rand_r%0d", r), got[r], kexp[r]);

        // Second key presented throughout EMIT must wait for the stream to end.
        key_b = 128'h0123456789abcdef_fedcba9876543210;
        stream(128'h0, 2, key_b);
        chk("held_r10", got[10], 128'h0);
        chk("held_r9", got[9], 128'h00000000_00000000_00000000_63636355);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("second_valid", 128'(out_valid), 128'(1'b1));
        chk("second_round", 128'(out_round), 128'(4'd10));
        chk("second_key", key_out, key_b);

        // Reset after the fourth accepted beat of the second stream.
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_round", 128'(out_round), 128'(4'd6));
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 128'(out_valid), 128'(1'b0));
        chk("mid_rst_busy", 128'(busy), 128'(1'b0));
        chk("mid_rst_in_ready", 128'(in_ready), 128'(1'b1));
        chk("mid_rst_round", 128'(out_round), 128'(4'd0));
        chk("mid_rst_rcon", 128'(dut.rcon_q), 128'(8'h00));
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst_valid", 128'(out_valid), 128'(1'b0));
        @(negedge clk);
        stream(kexp[10], 0, 128'h0);
        chk("restart_rcon", 128'(rcon_got[10]), 128'(8'h36));
        for (int r = 0; r <= 10; r++) chk($sformatf("restart_r%0d", r), got[r], kexp[r]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
